// File: rtl/ir_led_sched.sv
// Drives the single IR-status LED: one blink pattern per event source, served by
// fixed priority err > key > repeat with preemption/retrigger by equal-or-higher sources.
module ir_led_sched #(
  parameter int unsigned REP_ON_CYC = 2_500_000,
  parameter int unsigned KEY_ON_CYC = 5_000_000,
  parameter int unsigned ERR_ON_CYC = 2_500_000,
  parameter int unsigned OFF_CYC    = 2_500_000,
  parameter int unsigned ERR_BLINKS = 3,
  parameter int unsigned CNT_W      = 23
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       repeat_en,
  input  logic       key_vld,
  input  logic       err_flag,
  output logic       led,
  output logic       busy,
  output logic [1:0] src
);

  localparam int unsigned BLK_W = (ERR_BLINKS < 2) ? 1 : $clog2(ERR_BLINKS + 1);

  localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REP_ON_CYC - 1);
  localparam logic [CNT_W-1:0] KEY_LAST = CNT_W'(KEY_ON_CYC - 1);
  localparam logic [CNT_W-1:0] ERR_LAST = CNT_W'(ERR_ON_CYC - 1);
  localparam logic [CNT_W-1:0] OFF_LAST = CNT_W'(OFF_CYC - 1);

  localparam logic [1:0] SRC_NONE = 2'd0;
  localparam logic [1:0] SRC_REP  = 2'd1;
  localparam logic [1:0] SRC_KEY  = 2'd2;
  localparam logic [1:0] SRC_ERR  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2
  } state_t;

  // Bit order everywhere: [0] repeat, [1] key, [2] err (bit index = source id - 1).
  logic [2:0]       req_in;
  logic [2:0]       dly_q;
  logic [2:0]       rise;
  logic [2:0]       pend_q, pend_d;
  logic [2:0]       grant_mask;
  logic [1:0]       hp_id;
  logic [CNT_W-1:0] cur_last;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       src_q, src_d;
  logic [BLK_W-1:0] blinks_q, blinks_d;
  logic             led_q, busy_q;

  assign req_in = {err_flag, key_vld, repeat_en};

  // A granted pend is cleared even if the same source rises again on that edge.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_req
      assign rise[gi]   = req_in[gi] & ~dly_q[gi];
      assign pend_d[gi] = (pend_q[gi] | rise[gi]) & ~grant_mask[gi];
    end
  endgenerate

  always_comb begin
    hp_id = SRC_NONE;
    if (pend_q[0]) hp_id = SRC_REP;
    if (pend_q[1]) hp_id = SRC_KEY;
    if (pend_q[2]) hp_id = SRC_ERR;
  end

  always_comb begin
    case (src_q)
      SRC_ERR: cur_last = ERR_LAST;
      SRC_KEY: cur_last = KEY_LAST;
      default: cur_last = REP_LAST;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    src_d      = src_q;
    blinks_d   = blinks_q;
    grant_mask = 3'b000;
    // src_q is 0 in IDLE, so this covers both a fresh grant and a preempt/retrigger.
    if (hp_id != SRC_NONE && hp_id >= src_q) begin
      state_d  = ST_ON;
      cnt_d    = '0;
      src_d    = hp_id;
      blinks_d = (hp_id == SRC_ERR) ? BLK_W'(ERR_BLINKS) : BLK_W'(1);
      case (hp_id)
        SRC_ERR: grant_mask = 3'b100;
        SRC_KEY: grant_mask = 3'b010;
        default: grant_mask = 3'b001;
      endcase
    end else begin
      case (state_q)
        ST_ON: begin
          if (cnt_q == cur_last) begin
            cnt_d = '0;
            if (blinks_q == BLK_W'(1)) begin
              state_d = ST_IDLE;
              src_d   = SRC_NONE;
            end else begin
              state_d  = ST_OFF;
              blinks_d = blinks_q - BLK_W'(1);
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_OFF: begin
          if (cnt_q == OFF_LAST) begin
            cnt_d   = '0;
            state_d = ST_ON;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          src_d   = SRC_NONE;
        end
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      dly_q    <= 3'b000;
      pend_q   <= 3'b000;
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      src_q    <= SRC_NONE;
      blinks_q <= '0;
      led_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      dly_q    <= req_in;
      pend_q   <= pend_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      src_q    <= src_d;
      blinks_q <= blinks_d;
      led_q    <= (state_d == ST_ON);
      busy_q   <= (state_d != ST_IDLE);
    end
  end

  assign led  = led_q;
  assign busy = busy_q;
  assign src  = src_q;

endmodule
